// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - controller state/class enums and datapath select encodings
package ctrl_pkg;
  import opcode_pkg::*;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_TRAP      = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_BRANCH,
    CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
  } op_class_t;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JALR   = 2'd2;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
endpackage

// File: rtl/opcode_pkg.sv
// rtl/opcode_pkg.sv - RV32I base opcode constants shared across the core
package opcode_pkg;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
endpackage

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - combinational opcode to instruction class decode
module opcode_classifier
  import opcode_pkg::*;
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);
  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OP_REG:    op_class = CLS_ALU_R;
      OP_IMM:    op_class = CLS_ALU_I;
      OP_LOAD:   op_class = CLS_LOAD;
      OP_STORE:  op_class = CLS_STORE;
      OP_BRANCH: op_class = CLS_BRANCH;
      OP_JAL:    op_class = CLS_JAL;
      OP_JALR:   op_class = CLS_JALR;
      OP_LUI:    op_class = CLS_LUI;
      OP_AUIPC:  op_class = CLS_AUIPC;
      default:   op_class = CLS_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multi-cycle control FSM; ILLEGAL_OP_TRAP_EN routes illegal opcodes to TRAP
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       instret,
  output logic       bus_timeout,
  output logic [2:0] state_dbg
);
  state_t          state;
  op_class_t       cls;
  op_class_t       dec_cls;
  logic [CNT_W-1:0] wait_cnt;
  logic            in_wait;
  logic            limit_hit;

  opcode_classifier u_classifier (
    .opcode   (opcode),
    .op_class (dec_cls)
  );

  // Ready arriving on the limit cycle clears in_wait, so it beats the watchdog.
  assign in_wait   = (state == ST_FETCH && !imem_ready) || (state == ST_MEMORY && !dmem_ready);
  assign limit_hit = (TIMEOUT_CYCLES != 0) && in_wait && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RESET;
      cls         <= CLS_ALU_R;
      wait_cnt    <= '0;
      bus_timeout <= 1'b0;
    end else if (limit_hit) begin
      state       <= ST_HALT;
      bus_timeout <= 1'b1;
      wait_cnt    <= '0;
    end else begin
      wait_cnt <= (in_wait && TIMEOUT_CYCLES != 0) ? wait_cnt + 1'b1 : '0;
      case (state)
        ST_RESET: state <= ST_FETCH;
        ST_FETCH: if (imem_ready) state <= ST_DECODE;
        ST_DECODE: begin
          cls <= dec_cls;
`ifdef ILLEGAL_OP_TRAP_EN
          state <= (dec_cls == CLS_ILLEGAL) ? ST_TRAP : ST_EXECUTE;
`else
          state <= ST_EXECUTE;
`endif
        end
        ST_EXECUTE: begin
          if (cls == CLS_BRANCH)                         state <= ST_FETCH;
          else if (cls == CLS_LOAD || cls == CLS_STORE)  state <= ST_MEMORY;
          else                                           state <= ST_WRITEBACK;
        end
        ST_MEMORY: if (dmem_ready) state <= (cls == CLS_STORE) ? ST_FETCH : ST_WRITEBACK;
        ST_WRITEBACK: state <= ST_FETCH;
        default: state <= state;
      endcase
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_PLUS4;
    reg_write = 1'b0;
    wb_sel    = WB_SEL_ALU;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    instret   = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      ST_EXECUTE: begin
        alu_a_sel = (cls == CLS_AUIPC);
        alu_b_sel = !(cls == CLS_ALU_R || cls == CLS_BRANCH);
        if (cls == CLS_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
          instret  = 1'b1;
        end
      end
      ST_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_STORE);
        if (dmem_ready && cls == CLS_STORE) begin
          pc_write = 1'b1;
          instret  = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        reg_write = (cls != CLS_ILLEGAL);
        pc_write  = 1'b1;
        instret   = 1'b1;
        if (cls == CLS_LOAD)                         wb_sel = WB_SEL_MEM;
        else if (cls == CLS_JAL || cls == CLS_JALR)  wb_sel = WB_SEL_PC4;
        if (cls == CLS_JAL)                          pc_src = PC_SRC_BRANCH;
        else if (cls == CLS_JALR)                    pc_src = PC_SRC_JALR;
      end
      default: ;
    endcase
  end

  assign state_dbg = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench with per-instruction trace model
module tb_multicycle_controller;
  localparam int TO = 16;
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;
  localparam int C_JAL = 5, C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

  typedef struct packed {
    logic       rst_n;
    logic [6:0] op;
    logic       bt;
    logic       ir;
    logic       dr;
  } in_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_a;
    logic       alu_b;
    logic       instret;
    logic       bus_timeout;
    logic [2:0] state;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_write, pc_write, reg_write;
  logic alu_a_sel, alu_b_sel, instret, bus_timeout;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] state_dbg;
  out_t got;

  cyc_t tr[$];
  out_t expq[$];
  out_t cmp_e;
  int   n_chk = 0, n_pass = 0, n_cyc = 0;
  logic exp_to = 1'b0;
  logic [6:0] ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .instret(instret), .bus_timeout(bus_timeout), .state_dbg(state_dbg)
  );

  assign got = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write,
                wb_sel, alu_a_sel, alu_b_sel, instret, bus_timeout, state_dbg};

  always @(negedge clk) begin
    n_cyc++;
    if (expq.size() > 0) begin
      cmp_e = expq.pop_front();
      n_chk++;
      if (got === cmp_e) n_pass++;
      else $display("FAIL outputs cycle %0d got %b required %b", n_cyc, got, cmp_e);
    end
  end

  function automatic int cls_of(logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LD;
      7'b0100011: return C_ST;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  function automatic out_t so(logic [2:0] st);
    out_t o = '0;
    o.state = st;
    return o;
  endfunction

  task automatic push(input logic rn, input logic [6:0] op, input logic bt,
                      input logic ir, input logic dr, input out_t o);
    cyc_t c;
    c.i.rst_n = rn; c.i.op = op; c.i.bt = bt; c.i.ir = ir; c.i.dr = dr;
    o.bus_timeout = exp_to;
    c.o = o;
    tr.push_back(c);
  endtask

  task automatic do_reset();
    exp_to = 1'b0;
    repeat (2) push(1'b0, rop(), rb(), rb(), rb(), so(3'd0));
    push(1'b1, rop(), rb(), rb(), rb(), so(3'd0));
  endtask

  task automatic halt_trace();
    exp_to = 1'b1;
    repeat (3) push(1'b1, rop(), rb(), rb(), rb(), so(3'd6));
  endtask

  // One instruction from FETCH entry; ended=1 means the core needs a reset afterwards.
  task automatic build(input logic [6:0] op, input int wi, input int wd, input logic bt,
                       input bit abort_mem, output bit ended);
    int   c;
    out_t o;
    c = cls_of(op);
    ended = 1'b0;
    for (int k = 0; k <= wi; k++) begin
      o = so(3'd1);
      o.imem_req = 1'b1;
      if (k == wi) begin
        o.ir_write = 1'b1;
        push(1'b1, rop(), rb(), 1'b1, rb(), o);
      end else begin
        push(1'b1, rop(), rb(), 1'b0, rb(), o);
        if (k == TO) begin halt_trace(); ended = 1'b1; return; end
      end
    end
    push(1'b1, op, rb(), rb(), rb(), so(3'd2));
`ifdef ILLEGAL_OP_TRAP_EN
    if (c == C_ILL) begin
      repeat (3) push(1'b1, op, rb(), rb(), rb(), so(3'd7));
      ended = 1'b1;
      return;
    end
`endif
    o = so(3'd3);
    o.alu_a = (c == C_AUIPC);
    o.alu_b = !(c == C_R || c == C_BR);
    if (c == C_BR) begin
      o.pc_write = 1'b1;
      o.pc_src = bt ? 2'd1 : 2'd0;
      o.instret = 1'b1;
      push(1'b1, op, bt, rb(), rb(), o);
      return;
    end
    push(1'b1, op, rb(), rb(), rb(), o);
    if (c == C_LD || c == C_ST) begin
      for (int k = 0; k <= wd; k++) begin
        o = so(3'd4);
        o.dmem_req = 1'b1;
        o.dmem_we = (c == C_ST);
        if (k == wd) begin
          if (c == C_ST) begin o.pc_write = 1'b1; o.instret = 1'b1; end
          push(1'b1, op, rb(), rb(), 1'b1, o);
          if (c == C_ST) return;
        end else if (abort_mem && k == 1) begin
          exp_to = 1'b0;
          push(1'b0, op, rb(), rb(), 1'b0, so(3'd0));
          ended = 1'b1;
          return;
        end else begin
          push(1'b1, op, rb(), rb(), 1'b0, o);
          if (k == TO) begin halt_trace(); ended = 1'b1; return; end
        end
      end
    end
    o = so(3'd5);
    o.reg_write = (c != C_ILL);
    o.pc_write = 1'b1;
    o.instret = 1'b1;
    o.wb_sel = (c == C_LD) ? 2'd1 : (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd0;
    o.pc_src = (c == C_JAL) ? 2'd1 : (c == C_JALR) ? 2'd2 : 2'd0;
    push(1'b1, op, rb(), rb(), rb(), o);
  endtask

  task automatic play();
    cyc_t c;
    while (tr.size() > 0) begin
      c = tr.pop_front();
      @(posedge clk);
      #1;
      rst_n = c.i.rst_n;
      opcode = c.i.op;
      branch_taken = c.i.bt;
      imem_ready = c.i.ir;
      dmem_ready = c.i.dr;
      expq.push_back(c.o);
    end
  endtask

  task automatic check_lit(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s got %0d required %0d", name, act, req);
  endtask

  function automatic int idx_instret();
    for (int i = 0; i < tr.size(); i++) if (tr[i].o.instret) return i;
    return -1;
  endfunction

  function automatic int idx_state(logic [2:0] s);
    for (int i = 0; i < tr.size(); i++) if (tr[i].o.state == s) return i;
    return -1;
  endfunction

  initial begin
    bit   e;
    int   pick;
    logic [6:0] op;
    do_reset(); play();

    build(7'b0110011, 0, 0, 1'b0, 1'b0, e);
    check_lit("alu_len", tr.size(), 4);
    check_lit("alu_instret_idx", idx_instret(), 3);
    play();
    build(7'b0110011, 0, 0, 1'b0, 1'b0, e); play();
    build(7'b0000011, 0, 3, 1'b0, 1'b0, e);
    check_lit("load_len", tr.size(), 8);
    check_lit("load_instret_idx", idx_instret(), 7);
    play();
    build(7'b1100011, 0, 0, 1'b1, 1'b0, e);
    check_lit("branch_len", tr.size(), 3);
    play();
    build(7'b1100011, 0, 0, 1'b0, 1'b0, e); play();
    build(7'b0100011, 0, 0, 1'b0, 1'b0, e);
    check_lit("store_len", tr.size(), 4);
    play();
    build(7'b1100111, 0, 0, 1'b0, 1'b0, e); play();
    build(7'b1111111, 0, 0, 1'b0, 1'b0, e);
`ifdef ILLEGAL_OP_TRAP_EN
    check_lit("trap_idx", idx_state(3'd7), 2);
`else
    check_lit("nop_len", tr.size(), 4);
`endif
    play();
    if (e) begin do_reset(); play(); end

    build(7'b0110011, TO, 0, 1'b0, 1'b0, e); play();
    build(7'b0110011, TO + 4, 0, 1'b0, 1'b0, e);
    check_lit("fetch_halt_idx", idx_state(3'd6), 17);
    play();
    do_reset(); play();
    build(7'b0000011, 0, TO + 10, 1'b0, 1'b0, e); play();
    do_reset(); play();
    build(7'b0000011, 0, 5, 1'b0, 1'b1, e); play();
    do_reset(); play();

    for (int n = 0; n < 200; n++) begin
      pick = $urandom_range(0, 9);
      op = (pick < 9) ? ops[pick] : rop();
      build(op,
            ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 2),
            ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 2),
            rb(), ($urandom_range(0, 29) == 0), e);
      play();
      if (e) begin do_reset(); play(); end
    end

    @(posedge clk);
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
